spm_dp: RTL and testbench
=========================

Name: spm_dp

Overview:
- Parametrised successor to the scratchpad memory: true dual-port word-addressed SRAM with an instruction-fetch port (if_*) and a data-access port (mem_*), both on one clock.
- Adds what the first-generation SPM lacked:
  - an inferred RAM array;
  - registered reads with valid strobes;
  - per-byte write enables;
  - a post-reset zero-initialisation sweep with ready handshake;
  - same-address write-collision arbitration with a sticky error flag.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 12, word address width.
- DEPTH, 4096, number of words; must be ≤ 2**ADDR_W.
- INIT_ZERO, 1, 1 = clear all words after reset; 0 = skip the sweep.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- if_as  in  1  fetch-port access strobe
- if_rw  in  1  1 = write, 0 = read
- if_be  in  DATA_W/8  byte write enables; ignored on read
- if_addr  in  ADDR_W  word address
- if_wr_data  in  DATA_W  write data
- if_rd_data  out  DATA_W  registered read data
- if_rd_vld  out  1  read data valid
- if_rdy  out  1  port accepts requests
- mem_as, mem_rw, mem_be, mem_addr, mem_wr_data, mem_rd_data, mem_rd_vld, mem_rdy: same as the if_* group, for the data port
- init_done  out  1  high once the sweep has completed
- coll_err  out  1  sticky same-address write-collision flag

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - all rd_data = 0, rd_vld = 0, rdy = 0, init_done = 0, coll_err = 0;
  - FSM goes to INIT, init counter = 0.
- FSM states:
  - INIT: when INIT_ZERO = 1, writes 0 to address cnt with all byte enables set, cnt += 1 each cycle. After writing DEPTH-1, go to RUN. Duration is exactly DEPTH cycles.
  - When INIT_ZERO = 0, INIT lasts exactly one cycle with no writes.
  - RUN: both rdy = 1 and init_done = 1, asserted from the first RUN cycle. Stays in RUN until reset.
- Requests while rdy = 0 are ignored: no write, no rd_vld.
- Reset mid-sweep: restarts INIT at address 0. Contents that were already cleared are simply cleared again.
- Read (as = 1, rw = 0, rdy = 1) at cycle N: rd_data holds mem[addr] and rd_vld = 1 in cycle N+1, so latency is 1. rd_vld is high for one cycle per request. rd_data holds its last value while rd_vld = 0.
- Write (as = 1, rw = 1, rdy = 1): mem[addr] byte k is updated with wr_data byte k where be[k] = 1, visible from the next cycle. No rd_vld is produced.
- be = 0 with rw = 1 is a legal no-op.
- Read-during-write, same port: not possible, because one request per port per cycle.
- Cross-port, same cycle, same address, one read and one write: read-first. The reading port returns the old word.
- Both ports write the same address in the same cycle:
  - mem port wins for every byte it enables;
  - if-port bytes not enabled by the mem port are still written;
  - coll_err is set, and cleared only by reset.
- Different addresses never interact.
- Address ≥ DEPTH: writes are dropped; reads return 0 with rd_vld = 1. No error is flagged.
- No backpressure once in RUN: one request per port per cycle, sustained.

Decomposition:
- Package spm_pkg:
  - RW_READ = 1'b0, RW_WRITE = 1'b1;
  - FSM state encoding (ST_INIT, ST_RUN);
  - default DATA_W/ADDR_W constants shared with the CPU top.
- Sub-module spm_dp_ram:
  - a plain dual-port, read-first, byte-enable RAM;
  - no reset on the array; both ports are write-capable.
- spm_dp owns the FSM, the init mux on port A, collision merge, range check, valid strobes and the error flag.

Test Plan:
- Reset with INIT_ZERO = 1, DEPTH = 16:
  - rdy/init_done are low for exactly 16 cycles, then high;
  - reading addresses 0–15 returns 0x00000000;
  - requests during INIT produce no rd_vld.
- Write 0xDEADBEEF to address 5 on the if port, then read address 5 on the mem port next cycle: mem_rd_data = 0xDEADBEEF, with mem_rd_vld one cycle after the request.
- Byte enables:
  - write be = 4'b0101, data 0x11223344 over a word holding 0xAABBCCDD;
  - read back 0xAA22CC44.
- Same cycle, address 7, word holding 0x0:
  - if writes 0xFFFFFFFF with be = 1111, mem writes 0x12345678 with be = 0011;
  - read back 0xFFFF5678, and coll_err = 1 and stays 1 until rst_n is low.
- Same cycle, address 3 holding 0xA5A5A5A5: if reads while mem writes 0x5A5A5A5A; if_rd_data = 0xA5A5A5A5, and a later read returns 0x5A5A5A5A.
- Assert rst_n = 0 for one cycle mid-sweep (cycle 8 of 16):
  - all outputs return to 0;
  - the sweep restarts and completes 16 cycles after reset release.

Source files
------------

// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared constants and types for the dual-port scratchpad
package spm_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int SPM_DATA_W = 32;
    localparam int SPM_ADDR_W = 12;
    localparam int SPM_DEPTH  = 4096;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } spm_state_e;

endpackage

// File: rtl/spm_dp_ram.sv
// rtl/spm_dp_ram.sv - dual-port read-first byte-enable RAM array
//
// Ports (A and B identical, both on clk):
//   x_re       read enable; x_rd_data updates only when set
//   x_be       byte write enables (one bit per byte)
//   x_addr     word address, must be < DEPTH when x_re or x_be is active
//   x_wr_data  write data
//   x_rd_data  registered read data (old contents on same-cycle write)
// The caller guarantees that the two ports never enable the same byte of
// the same word in one cycle.
module spm_dp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic                clk,
    input  logic                a_re,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wr_data,
    output logic [DATA_W-1:0]   a_rd_data,
    input  logic                b_re,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wr_data,
    output logic [DATA_W-1:0]   b_rd_data
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < BE_W; k++) begin
            if (a_be[k]) mem[a_addr][k*8 +: 8] <= a_wr_data[k*8 +: 8];
            if (b_be[k]) mem[b_addr][k*8 +: 8] <= b_wr_data[k*8 +: 8];
        end
        if (a_re) a_rd_data <= mem[a_addr];
        if (b_re) b_rd_data <= mem[b_addr];
    end

endmodule

// File: rtl/spm_dp.sv
// rtl/spm_dp.sv - dual-port scratchpad with init sweep and collision flag
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_*  / mem_*              fetch / data request ports: as, rw, be, addr,
//                              wr_data in; rd_data, rd_vld, rdy out
//   init_done                  high once the zero sweep has finished
//   coll_err                   sticky same-address dual-write flag
module spm_dp
    import spm_pkg::*;
#(
    parameter int DATA_W    = SPM_DATA_W,
    parameter int ADDR_W    = SPM_ADDR_W,
    parameter int DEPTH     = SPM_DEPTH,
    parameter int INIT_ZERO = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_as,
    input  logic                if_rw,
    input  logic [DATA_W/8-1:0] if_be,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic [DATA_W-1:0]   if_wr_data,
    output logic [DATA_W-1:0]   if_rd_data,
    output logic                if_rd_vld,
    output logic                if_rdy,
    input  logic                mem_as,
    input  logic                mem_rw,
    input  logic [DATA_W/8-1:0] mem_be,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wr_data,
    output logic [DATA_W-1:0]   mem_rd_data,
    output logic                mem_rd_vld,
    output logic                mem_rdy,
    output logic                init_done,
    output logic                coll_err
);

    localparam int                BE_W      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    spm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              run;

    logic if_in, mem_in;
    logic if_acc_rd, mem_acc_rd, if_re, mem_re, if_wr, mem_wr, collide;

    logic [BE_W-1:0]   a_be, b_be;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wr_data, a_rd_data, b_rd_data;

    // Out-of-range reads still complete; this flag forces their data to zero
    // and keeps rd_data at zero straight out of reset.
    logic if_zero_q, mem_zero_q;
    logic if_vld_q, mem_vld_q, coll_q;

    assign run    = (state_q == ST_RUN);
    assign if_in  = ({1'b0, if_addr}  < DEPTH_X);
    assign mem_in = ({1'b0, mem_addr} < DEPTH_X);

    assign if_acc_rd  = run && if_as  && (if_rw  == RW_READ);
    assign mem_acc_rd = run && mem_as && (mem_rw == RW_READ);
    assign if_re      = if_acc_rd  && if_in;
    assign mem_re     = mem_acc_rd && mem_in;
    assign if_wr      = run && if_as  && (if_rw  == RW_WRITE) && if_in;
    assign mem_wr     = run && mem_as && (mem_rw == RW_WRITE) && mem_in;
    assign collide    = if_wr && mem_wr && (if_addr == mem_addr);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (INIT_ZERO == 0 || cnt_q == LAST_ADDR) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Port A doubles as the sweep writer; during RUN the fetch port drives it,
    // giving up any bytes the data port also writes to the same word.
    always_comb begin
        a_be      = '0;
        a_addr    = if_addr;
        a_wr_data = if_wr_data;
        if (state_q == ST_INIT) begin
            if (INIT_ZERO != 0) begin
                a_be      = '1;
                a_addr    = cnt_q;
                a_wr_data = '0;
            end
        end else if (if_wr) begin
            a_be = collide ? (if_be & ~mem_be) : if_be;
        end
    end

    assign b_be = mem_wr ? mem_be : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            if_vld_q   <= 1'b0;
            mem_vld_q  <= 1'b0;
            if_zero_q  <= 1'b1;
            mem_zero_q <= 1'b1;
            coll_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (state_q == ST_INIT) cnt_q <= cnt_q + 1'b1;
            if_vld_q  <= if_acc_rd;
            mem_vld_q <= mem_acc_rd;
            if (if_acc_rd)  if_zero_q  <= !if_in;
            if (mem_acc_rd) mem_zero_q <= !mem_in;
            if (collide)    coll_q     <= 1'b1;
        end
    end

    spm_dp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .a_re      (if_re),
        .a_be      (a_be),
        .a_addr    (a_addr),
        .a_wr_data (a_wr_data),
        .a_rd_data (a_rd_data),
        .b_re      (mem_re),
        .b_be      (b_be),
        .b_addr    (mem_addr),
        .b_wr_data (mem_wr_data),
        .b_rd_data (b_rd_data)
    );

    assign if_rd_data  = if_zero_q  ? '0 : a_rd_data;
    assign mem_rd_data = mem_zero_q ? '0 : b_rd_data;
    assign if_rd_vld   = if_vld_q;
    assign mem_rd_vld  = mem_vld_q;
    assign if_rdy      = run;
    assign mem_rdy     = run;
    assign init_done   = run;
    assign coll_err    = coll_q;

endmodule

// File: tb/tb_spm_dp.sv
// tb/tb_spm_dp.sv - directed self-checking bench for spm_dp
module tb_spm_dp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_as, if_rw, mem_as, mem_rw;
    logic [3:0]  if_be, mem_be;
    logic [4:0]  if_addr, mem_addr;
    logic [31:0] if_wr_data, mem_wr_data, if_rd_data, mem_rd_data;
    logic        if_rd_vld, if_rdy, mem_rd_vld, mem_rdy, init_done, coll_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int n;
    logic seen_vld;

    always #5 clk = ~clk;

    spm_dp #(
        .DATA_W    (32),
        .ADDR_W    (5),
        .DEPTH     (16),
        .INIT_ZERO (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_as       (if_as),
        .if_rw       (if_rw),
        .if_be       (if_be),
        .if_addr     (if_addr),
        .if_wr_data  (if_wr_data),
        .if_rd_data  (if_rd_data),
        .if_rd_vld   (if_rd_vld),
        .if_rdy      (if_rdy),
        .mem_as      (mem_as),
        .mem_rw      (mem_rw),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_rd_vld  (mem_rd_vld),
        .mem_rdy     (mem_rdy),
        .init_done   (init_done),
        .coll_err    (coll_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drv_if(input logic as, input logic rw, input logic [3:0] be,
                          input logic [4:0] addr, input logic [31:0] data);
        if_as = as; if_rw = rw; if_be = be; if_addr = addr; if_wr_data = data;
    endtask

    task automatic drv_mem(input logic as, input logic rw, input logic [3:0] be,
                           input logic [4:0] addr, input logic [31:0] data);
        mem_as = as; mem_rw = rw; mem_be = be; mem_addr = addr; mem_wr_data = data;
    endtask

    task automatic idle();
        drv_if(0, 0, 4'h0, 5'd0, 32'h0);
        drv_mem(0, 0, 4'h0, 5'd0, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " if_rdy"}, {31'b0, if_rdy}, 32'd0);
        chk({tag, " mem_rdy"}, {31'b0, mem_rdy}, 32'd0);
        chk({tag, " init_done"}, {31'b0, init_done}, 32'd0);
        chk({tag, " coll_err"}, {31'b0, coll_err}, 32'd0);
        chk({tag, " if_rd_vld"}, {31'b0, if_rd_vld}, 32'd0);
        chk({tag, " mem_rd_vld"}, {31'b0, mem_rd_vld}, 32'd0);
        chk({tag, " if_rd_data"}, if_rd_data, 32'd0);
        chk({tag, " mem_rd_data"}, mem_rd_data, 32'd0);
    endtask

    // Counts cycles until rdy rises with both ports issuing reads; none may
    // produce a valid strobe while the sweep is running.
    task automatic wait_sweep(input string tag);
        n = 0;
        seen_vld = 1'b0;
        drv_if(1, 0, 4'h0, 5'd2, 32'h0);
        drv_mem(1, 0, 4'h0, 5'd3, 32'h0);
        while (!if_rdy && n < 100) begin
            tick();
            n++;
            if (if_rd_vld || mem_rd_vld) seen_vld = 1'b1;
        end
        chk({tag, " sweep cycles"}, n, 32'd16);
        chk({tag, " no vld during init"}, {31'b0, seen_vld}, 32'd0);
        chk({tag, " init_done"}, {31'b0, init_done}, 32'd1);
        chk({tag, " mem_rdy"}, {31'b0, mem_rdy}, 32'd1);
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        chk_reset_outputs("reset");

        rst_n = 1'b1;
        wait_sweep("sweep1");

        // Sustained back-to-back reads of the whole array on both ports
        for (int a = 0; a < 16; a++) begin
            drv_if(1, 0, 4'h0, 5'(a), 32'h0);
            drv_mem(1, 0, 4'h0, 5'(15 - a), 32'h0);
            tick();
            chk($sformatf("zero if[%0d]", a), if_rd_data, 32'h0);
            chk($sformatf("zero if vld[%0d]", a), {31'b0, if_rd_vld}, 32'd1);
            chk($sformatf("zero mem[%0d]", 15 - a), mem_rd_data, 32'h0);
            chk($sformatf("zero mem vld[%0d]", 15 - a), {31'b0, mem_rd_vld}, 32'd1);
        end
        idle();

        // Cross-port write then read, with hold after the strobe
        drv_if(1, 1, 4'hF, 5'd5, 32'hDEADBEEF);
        tick();
        chk("write no vld", {31'b0, if_rd_vld}, 32'd0);
        idle();
        drv_mem(1, 0, 4'h0, 5'd5, 32'h0);
        tick();
        chk("xport rd data", mem_rd_data, 32'hDEADBEEF);
        chk("xport rd vld", {31'b0, mem_rd_vld}, 32'd1);
        idle();
        tick();
        chk("vld one cycle", {31'b0, mem_rd_vld}, 32'd0);
        chk("rd data hold", mem_rd_data, 32'hDEADBEEF);

        // Byte enables
        drv_mem(1, 1, 4'hF, 5'd9, 32'hAABBCCDD);
        tick();
        drv_mem(1, 1, 4'b0101, 5'd9, 32'h11223344);
        tick();
        drv_mem(1, 1, 4'b0000, 5'd9, 32'h00000000);
        tick();
        idle();
        drv_if(1, 0, 4'h0, 5'd9, 32'h0);
        tick();
        chk("byte enable merge", if_rd_data, 32'hAA22CC44);
        idle();

        // Same-address dual write
        chk("coll_err clear", {31'b0, coll_err}, 32'd0);
        drv_if(1, 1, 4'hF, 5'd7, 32'hFFFFFFFF);
        drv_mem(1, 1, 4'b0011, 5'd7, 32'h12345678);
        tick();
        chk("coll_err set", {31'b0, coll_err}, 32'd1);
        idle();
        drv_mem(1, 0, 4'h0, 5'd7, 32'h0);
        tick();
        chk("collision merge", mem_rd_data, 32'hFFFF5678);
        idle();

        // Read-first across ports
        drv_if(1, 1, 4'hF, 5'd3, 32'hA5A5A5A5);
        tick();
        drv_if(1, 0, 4'h0, 5'd3, 32'h0);
        drv_mem(1, 1, 4'hF, 5'd3, 32'h5A5A5A5A);
        tick();
        chk("read-first old", if_rd_data, 32'hA5A5A5A5);
        chk("read-first vld", {31'b0, if_rd_vld}, 32'd1);
        drv_mem(0, 0, 4'h0, 5'd0, 32'h0);
        tick();
        chk("read-first new", if_rd_data, 32'h5A5A5A5A);
        idle();

        // Independent writes to different addresses
        drv_if(1, 1, 4'hF, 5'd1, 32'h01010101);
        drv_mem(1, 1, 4'hF, 5'd2, 32'h02020202);
        tick();
        drv_if(1, 0, 4'h0, 5'd2, 32'h0);
        drv_mem(1, 0, 4'h0, 5'd1, 32'h0);
        tick();
        chk("diff addr if", if_rd_data, 32'h02020202);
        chk("diff addr mem", mem_rd_data, 32'h01010101);

        // Out-of-range: write dropped (no alias onto 4), read returns zero
        drv_if(1, 1, 4'hF, 5'd20, 32'h12345678);
        drv_mem(0, 0, 4'h0, 5'd0, 32'h0);
        tick();
        drv_if(1, 0, 4'h0, 5'd4, 32'h0);
        drv_mem(1, 0, 4'h0, 5'd20, 32'h0);
        tick();
        chk("oor rd data", mem_rd_data, 32'h0);
        chk("oor rd vld", {31'b0, mem_rd_vld}, 32'd1);
        chk("oor no alias", if_rd_data, 32'h0);
        idle();
        tick();
        chk("coll_err sticky", {31'b0, coll_err}, 32'd1);

        // Reset in RUN clears everything, then reset again mid-sweep
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("run reset");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("mid-sweep rdy low", {31'b0, if_rdy}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("mid reset");
        rst_n = 1'b1;
        wait_sweep("sweep2");

        drv_if(1, 0, 4'h0, 5'd5, 32'h0);
        drv_mem(1, 0, 4'h0, 5'd7, 32'h0);
        tick();
        chk("recleared 5", if_rd_data, 32'h0);
        chk("recleared 7", mem_rd_data, 32'h0);
        chk("recleared vld", {31'b0, if_rd_vld}, 32'd1);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
